tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Round-robin arbiter and sequencer that shares one serial transceiver among NREQ requesters. It drives the transceiver's DataIn/SampleData/StartTx inputs and watches its TxBusy/TxDone outputs. It performs the full load → start → wait-done sequence for the granted requester, and aborts with an error if the transceiver stalls. It sits between the parallel producers and the transceiver, in the same clock domain as the transceiver's control clock.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DinLENGTH, 32: transceiver word width.
- TIMEOUT, 1023: max Clk cycles allowed in START or WAIT before abort; ≥ 1.

- Clk  in  1  single clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Req  in  NREQ  per-requester level request; hold until ReqDone or Error for that bit.
- ReqData  in  NREQ*DinLENGTH  requester i word at bits [i*DinLENGTH +: DinLENGTH].
- Grant  out  NREQ  one-hot owner of the transceiver; all-zero when idle.
- ReqDone  out  NREQ  one-cycle pulse on the granted bit when transmission completes.
- Error  out  NREQ  one-cycle pulse on the granted bit on timeout abort.
- DataIn  out  DinLENGTH  word presented to the transceiver.
- SampleData  out  1  transceiver load strobe.
- StartTx  out  1  transceiver start request.
- TxBusy  in  1  transceiver busy status.
- TxDone  in  1  transceiver completion pulse.

## Operation
- FSM states: IDLE, SAMPLE, START, WAIT, DONE, ERR.
- IDLE: if any Req bit is set, pick the winner by round-robin and register Grant. Then go to SAMPLE.
- Round-robin: search starts at Ptr, wraps modulo NREQ. On leaving DONE or ERR, Ptr = granted index + 1, wrapping at NREQ. Reset value of Ptr is 0.
- SAMPLE (1 cycle): SampleData=1, DataIn = ReqData slice of the granted index, StartTx=0. Then go to START.
- START: StartTx=1, SampleData=0.
  - TxBusy==1 → WAIT.
  - Timeout → ERR.
- WAIT: StartTx=0.
  - TxDone==1 → DONE.
  - Timeout → ERR.
- DONE (1 cycle): ReqDone[g]=1. Then go to IDLE.
- ERR (1 cycle): Error[g]=1, ReqDone stays 0. Then go to IDLE.
- Grant is held from SAMPLE through DONE/ERR and is all-zero in IDLE.
- SampleData and StartTx are never 1 in the same cycle.
- DataIn is registered and holds its last loaded value outside SAMPLE.
- Timeout counter:
  - width $clog2(TIMEOUT+1); cleared on entry to START and on entry to WAIT.
  - increments every cycle in START/WAIT.
  - timeout fires when the count equals TIMEOUT and the exit condition is not met that cycle.
  - if the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Req dropped while granted: the transaction still completes and ReqDone still pulses.
- Req bits of non-granted requesters are ignored until IDLE.
- TxDone or TxBusy seen in IDLE/SAMPLE: ignored, no state change.
- Reset (Reset=0), at any time including mid-transaction:
  - state → IDLE; Grant, ReqDone, Error, SampleData, StartTx → 0; DataIn → 0; Ptr → 0; counter → 0.
  - the transceiver is expected to be reset by the same net.

## Timing
- Request accepted in IDLE at edge n → Grant and SampleData valid after edge n+1. StartTx asserts after edge n+2.
- StartTx drops in the cycle after TxBusy is sampled high.
- ReqDone pulses in the cycle after TxDone is sampled high.
- Best-case overhead per transaction beyond transceiver time: IDLE + SAMPLE + START(1) + DONE = 4 cycles. The next Grant follows 2 cycles after the ReqDone pulse cycle.
- All outputs are registered; no combinational input→output paths.

## Test plan
- Single request: Req=4'b0010, ReqData[63:32]=32'hA5A5_1234; transceiver model asserts TxBusy 1 cycle after StartTx and TxDone after 8 ClkTx words → Grant=0010, one SampleData pulse with DataIn=A5A5_1234, ReqDone=0010 for exactly 1 cycle, Grant back to 0.
- Simultaneous requests: Req=4'b1011 held after reset → grant order 0,1,3,0, each with a single ReqDone pulse; Grant never has more than one bit set.
- Stalled transceiver: TxBusy tied 0, TIMEOUT=15 → StartTx high for 16 cycles, then Error pulse on the granted bit, ReqDone=0, FSM in IDLE, Ptr advanced.
- Missing TxDone: TxBusy goes high, TxDone never arrives → Error after TIMEOUT+1 WAIT cycles; the next requester is granted afterwards.
- Reset mid-WAIT: Reset=0 for 1 cycle → all outputs 0 immediately (asynchronous); a new request after release is granted starting at index 0.
- Spurious TxDone in IDLE plus Req dropped during WAIT → no ReqDone for the spurious pulse; the dropped-Req transaction still gets its ReqDone.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one serial transceiver among NREQ requesters,
// sequencing load -> start -> wait-done and aborting on a transceiver stall.
module tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DinLENGTH = 32,
  parameter int TIMEOUT   = 1023
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*DinLENGTH-1:0] ReqData,
  output logic [NREQ-1:0]           Grant,
  output logic [NREQ-1:0]           ReqDone,
  output logic [NREQ-1:0]           Error,
  output logic [DinLENGTH-1:0]      DataIn,
  output logic                      SampleData,
  output logic                      StartTx,
  input  logic                      TxBusy,
  input  logic                      TxDone
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_START, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t                 state_reg;
  logic [IW-1:0]          ptr_reg;
  logic [IW-1:0]          idx_reg;
  logic [CW-1:0]          cnt_reg;
  logic [NREQ-1:0]        grant_reg;
  logic [NREQ-1:0]        done_reg;
  logic [NREQ-1:0]        err_reg;
  logic [DinLENGTH-1:0]   data_reg;
  logic                   sample_reg;
  logic                   start_reg;

  logic [DinLENGTH-1:0]   req_word [NREQ];
  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic [NREQ-1:0]        win_onehot;
  logic [IW:0]            cand_sum;
  logic [IW-1:0]          cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign req_word[gi] = ReqData[gi*DinLENGTH +: DinLENGTH];
    end
  endgenerate

  // Scan from ptr upward, wrapping at NREQ; first set request wins.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, ptr_reg} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(NREQ))
        cand_sum = cand_sum - (IW+1)'(NREQ);
      cand = cand_sum[IW-1:0];
      if (!win_found && Req[cand]) begin
        win_found        = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      grant_reg  <= '0;
      done_reg   <= '0;
      err_reg    <= '0;
      data_reg   <= '0;
      sample_reg <= 1'b0;
      start_reg  <= 1'b0;
    end else begin
      done_reg <= '0;
      err_reg  <= '0;
      case (state_reg)
        S_IDLE: begin
          if (win_found) begin
            grant_reg  <= win_onehot;
            idx_reg    <= win_idx;
            data_reg   <= req_word[win_idx];
            sample_reg <= 1'b1;
            state_reg  <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          sample_reg <= 1'b0;
          start_reg  <= 1'b1;
          cnt_reg    <= '0;
          state_reg  <= S_START;
        end
        S_START: begin
          // Exit condition is tested first so it beats a same-cycle timeout.
          if (TxBusy) begin
            start_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= S_WAIT;
          end else if (cnt_reg == TMAX) begin
            start_reg <= 1'b0;
            err_reg   <= grant_reg;
            state_reg <= S_ERR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_WAIT: begin
          if (TxDone) begin
            done_reg  <= grant_reg;
            state_reg <= S_DONE;
          end else if (cnt_reg == TMAX) begin
            err_reg   <= grant_reg;
            state_reg <= S_ERR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          grant_reg <= '0;
          cnt_reg   <= '0;
          ptr_reg   <= (idx_reg == LAST) ? '0 : idx_reg + IW'(1);
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign Grant      = grant_reg;
  assign ReqDone    = done_reg;
  assign Error      = err_reg;
  assign DataIn     = data_reg;
  assign SampleData = sample_reg;
  assign StartTx    = start_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a transaction-level reference model checked every
// cycle, a simple transceiver model, and literal checks on key scenario outcomes.
module tb_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TMO  = 15;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [NREQ-1:0]   Req = '0;
  logic [NREQ*DW-1:0] ReqData = '0;
  logic [NREQ-1:0]   Grant, ReqDone, Error;
  logic [DW-1:0]     DataIn;
  logic              SampleData, StartTx;
  logic              TxBusy, TxDone;

  always #5 Clk = ~Clk;

  tx_arbiter #(.NREQ(NREQ), .DinLENGTH(DW), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqData(ReqData),
    .Grant(Grant), .ReqDone(ReqDone), .Error(Error), .DataIn(DataIn),
    .SampleData(SampleData), .StartTx(StartTx), .TxBusy(TxBusy), .TxDone(TxDone)
  );

  // ---------------- transceiver model: 0 normal, 1 stalled, 2 never done
  int xmode = 0;
  int spur_req = 0;
  int spur_ack;
  int tx_cnt;

  initial begin
    TxBusy = 1'b0; TxDone = 1'b0; tx_cnt = 0; spur_ack = 0;
    forever begin
      @(posedge Clk); #2;
      TxDone = 1'b0;
      if (!Reset) begin
        TxBusy = 1'b0; tx_cnt = 0;
      end else if (spur_req != spur_ack) begin
        TxDone = 1'b1; spur_ack++;
      end else if (xmode == 0) begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) begin TxDone = 1'b1; TxBusy = 1'b0; end
        end else begin
          TxBusy = StartTx;
          if (StartTx) tx_cnt = 8;
        end
      end else if (xmode == 1) begin
        TxBusy = 1'b0; tx_cnt = 0;
      end else begin
        TxBusy = TxBusy | StartTx;
      end
    end
  end

  // ---------------- reference model: expected outputs after each edge
  logic [NREQ-1:0] exp_grant, exp_done, exp_err;
  logic [DW-1:0]   exp_data;
  logic            exp_sd, exp_st;
  int m_owner, m_ptr, m_age, m_c;

  initial begin
    exp_grant = '0; exp_done = '0; exp_err = '0; exp_data = '0;
    exp_sd = 1'b0; exp_st = 1'b0; m_owner = -1; m_ptr = 0; m_age = 0; m_c = 0;
    forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
        exp_grant = '0; exp_done = '0; exp_err = '0; exp_data = '0;
        exp_sd = 1'b0; exp_st = 1'b0; m_owner = -1; m_ptr = 0; m_age = 0;
      end else if (exp_done != 0 || exp_err != 0) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
        exp_grant = '0; exp_done = '0; exp_err = '0;
      end else if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_ptr + k) % NREQ;
          if (m_owner < 0 && ((Req >> m_c) & 4'b0001) != 0) m_owner = m_c;
        end
        if (m_owner >= 0) begin
          exp_grant = 4'(1 << m_owner);
          exp_data  = 32'(ReqData >> (m_owner * DW));
          exp_sd    = 1'b1;
        end
      end else if (exp_sd) begin
        exp_sd = 1'b0; exp_st = 1'b1; m_age = 0;
      end else if (exp_st) begin
        if (TxBusy) begin exp_st = 1'b0; m_age = 0; end
        else if (m_age == TMO) begin exp_st = 1'b0; exp_err = exp_grant; end
        else m_age++;
      end else begin
        if (TxDone) exp_done = exp_grant;
        else if (m_age == TMO) exp_err = exp_grant;
        else m_age++;
      end
    end
  end

  // ---------------- checking and observation
  int vectors = 0;
  int miscompares = 0;
  int sd_cnt, st_cnt, wt_cnt, done_cnt, txn_no;
  logic [DW-1:0] last_data;
  int grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (((g >> i) & 4'b0001) != 0) r = i;
    return r;
  endfunction

  task automatic clr_obs();
    sd_cnt = 0; st_cnt = 0; wt_cnt = 0; done_cnt = 0; last_data = '0;
    grant_log.delete();
  endtask

  task automatic tick();
    @(posedge Clk); #1;
    chk("grant",   32'(Grant),      32'(exp_grant));
    chk("reqdone", 32'(ReqDone),    32'(exp_done));
    chk("error",   32'(Error),      32'(exp_err));
    chk("datain",  DataIn,          exp_data);
    chk("sample",  32'(SampleData), 32'(exp_sd));
    chk("starttx", 32'(StartTx),    32'(exp_st));
    if (SampleData) begin sd_cnt++; last_data = DataIn; grant_log.push_back(oh_idx(Grant)); end
    if (StartTx) st_cnt++;
    if (Grant != 0 && !SampleData && !StartTx && ReqDone == 0 && Error == 0) wt_cnt++;
    if (ReqDone != 0) done_cnt++;
    if (ReqDone != 0 || Error != 0) begin
      txn_no++;
      $display("txn %0d: grant=%b reqdone=%b error=%b datain=%h", txn_no, Grant, ReqDone, Error, DataIn);
    end
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (ReqDone == 0 && Error == 0 && n < budget);
    if (ReqDone == 0 && Error == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: no ReqDone/Error within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_in_wait(input string name, input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (!(TxBusy && !StartTx && Grant != 0) && n < budget);
    if (!(TxBusy && !StartTx && Grant != 0)) begin
      vectors++; miscompares++;
      $display("FAIL %s: transfer never reached wait phase within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0; tick(); Reset = 1'b1; tick();
  endtask

  initial begin
    txn_no = 0;
    clr_obs();
    ReqData = {32'h3333_CAFE, 32'h2222_BEEF, 32'hA5A5_1234, 32'h0000_F00D};
    tick(); tick();
    chk("rst_grant", 32'(Grant), 32'h0);
    Reset = 1'b1;
    tick();

    // single request
    clr_obs();
    Req = 4'b0010;
    wait_end("t1", 60);
    Req = 4'b0000;
    chk("t1_reqdone", 32'(ReqDone), 32'b0010);
    chk("t1_sd_cnt", 32'(sd_cnt), 32'd1);
    chk("t1_data", last_data, 32'hA5A5_1234);
    chk("t1_grant_idx", 32'(grant_log[0]), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(ReqDone), 32'h0);
    chk("t1_grant_idle", 32'(Grant), 32'h0);

    // simultaneous requests held after reset
    do_reset();
    clr_obs();
    Req = 4'b1011;
    for (int t = 0; t < 4; t++) wait_end("t2", 60);
    Req = 4'b0000;
    chk("t2_ntxn", 32'(grant_log.size()), 32'd4);
    chk("t2_order0", 32'(grant_log[0]), 32'd0);
    chk("t2_order1", 32'(grant_log[1]), 32'd1);
    chk("t2_order2", 32'(grant_log[2]), 32'd3);
    chk("t2_order3", 32'(grant_log[3]), 32'd0);
    chk("t2_dones", 32'(done_cnt), 32'd4);
    tick();

    // stalled transceiver: pointer is 1, so requester 2 wins
    xmode = 1;
    clr_obs();
    Req = 4'b0100;
    wait_end("t3", 60);
    Req = 4'b0000;
    chk("t3_error", 32'(Error), 32'b0100);
    chk("t3_reqdone", 32'(ReqDone), 32'h0);
    chk("t3_start_cycles", 32'(st_cnt), 32'd16);
    tick();
    chk("t3_idle", 32'(Grant), 32'h0);

    // missing TxDone: pointer advanced to 3
    xmode = 2;
    clr_obs();
    Req = 4'b1001;
    wait_end("t4", 80);
    chk("t4_error", 32'(Error), 32'b1000);
    chk("t4_wait_cycles", 32'(wt_cnt), 32'd16);
    chk("t4_grant_idx", 32'(grant_log[0]), 32'd3);
    Req = 4'b0001;
    xmode = 0;
    wait_end("t4b", 60);
    Req = 4'b0000;
    chk("t4_next_done", 32'(ReqDone), 32'b0001);
    chk("t4_next_idx", 32'(grant_log[1]), 32'd0);
    tick();

    // reset mid-wait
    clr_obs();
    Req = 4'b0100;
    wait_in_wait("t5", 40);
    tick(); tick();
    Reset = 1'b0;
    Req = 4'b0011;
    #1;
    chk("t5_async_grant", 32'(Grant), 32'h0);
    chk("t5_async_done", 32'(ReqDone), 32'h0);
    chk("t5_async_err", 32'(Error), 32'h0);
    chk("t5_async_sd", 32'(SampleData), 32'h0);
    chk("t5_async_st", 32'(StartTx), 32'h0);
    chk("t5_async_data", DataIn, 32'h0);
    tick();
    Reset = 1'b1;
    clr_obs();
    wait_end("t5b", 60);
    Req = 4'b0000;
    chk("t5_ptr_zero", 32'(grant_log[0]), 32'd0);
    chk("t5_done", 32'(ReqDone), 32'b0001);
    tick();

    // spurious TxDone in IDLE, then Req dropped during WAIT
    clr_obs();
    spur_req++;
    tick(); tick(); tick();
    chk("t6_spurious", 32'(done_cnt), 32'd0);
    Req = 4'b0100;
    wait_in_wait("t6", 40);
    Req = 4'b0000;
    wait_end("t6b", 60);
    chk("t6_done", 32'(ReqDone), 32'b0100);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
